lsu_bus_ctrl: RTL

- Load/store controller directly downstream of the ALU: consumes ALUResult as the effective address for loads and stores.
- Converts the core's memory request into a valid/ready transaction on the data-memory bus.
- Handles byte/halfword lane steering and load sign/zero extension.
- Holds Busy while the bus is outstanding, so the core stalls.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_bus_ctrl_if.sv | 21 ++
 rtl/lsu_lane_align.sv | 40 ++++
 rtl/lsu_bus_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, Funct3 encodings and access-legality helpers for the load/store bus controller.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP,
      DONE
   } lsu_state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam int DEF_TIMEOUT_CYCLES = 16;

   // Unsigned stores do not exist, and 011/11x have no size encoding.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      return ((f3[1:0] == F3_LH[1:0]) && lo[0]) ||
             ((f3[1:0] == F3_LW[1:0]) && (lo != 2'b00));
   endfunction

   function automatic logic [1:0] force_align(input logic [2:0] f3, input logic [1:0] lo);
      if (f3[1:0] == F3_LH[1:0]) return {lo[1], 1'b0};
      if (f3[1:0] == F3_LW[1:0]) return 2'b00;
      return lo;
   endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// Valid/ready data-memory bus between the load/store controller (master) and memory (slave).
interface lsu_bus_ctrl_if;
   logic        BusValid;
   logic        BusReady;
   logic        BusWe;
   logic [31:0] BusAddr;
   logic [31:0] BusWData;
   logic [3:0]  BusStrb;
   logic        BusRValid;
   logic [31:0] BusRData;

   modport master (
      output BusValid, BusWe, BusAddr, BusWData, BusStrb,
      input  BusReady, BusRValid, BusRData
   );

   modport slave (
      input  BusValid, BusWe, BusAddr, BusWData, BusStrb,
      output BusReady, BusRValid, BusRData
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store strobes/data replication and load lane select + extension.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  strb,
   output logic [31:0] lane_wdata,
   output logic [31:0] rdata_ext
);
   logic [1:0]  size;
   logic [31:0] rdata_shift;

   assign size        = funct3[1:0];
   assign rdata_shift = rdata >> {addr_lo, 3'b000};

   // Replicate the narrow store datum into every lane; strobes pick the live one.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_wdata[8*gi +: 8] = (size == F3_SB[1:0]) ? wdata[7:0] :
                                        (size == F3_SH[1:0]) ? wdata[8*(gi%2) +: 8] :
                                                               wdata[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      strb      = 4'b1111;
      rdata_ext = rdata_shift;
      if (size == F3_LB[1:0]) begin
         strb      = 4'b0001 << addr_lo;
         rdata_ext = {{24{rdata_shift[7] & ~funct3[2]}}, rdata_shift[7:0]};
      end else if (size == F3_LH[1:0]) begin
         strb      = 4'b0011 << addr_lo;
         rdata_ext = {{16{rdata_shift[15] & ~funct3[2]}}, rdata_shift[15:0]};
      end
   end
endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store controller: turns a core memory request into one valid/ready data-memory bus transaction.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of aligning them.
module lsu_bus_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           Req,
   input  logic           MemWrite,
   input  logic [2:0]     Funct3,
   input  logic [31:0]    Addr,
   input  logic [31:0]    WriteData,
   output logic [31:0]    ReadData,
   output logic           Busy,
   output logic           Done,
   output logic           Fault,
   lsu_bus_ctrl_if.master bus
);
   lsu_state_t      state_reg;
   logic [2:0]      funct3_reg;
   logic            we_reg;
   logic [1:0]      addr_lo_reg;
   logic [TO_W-1:0] cnt_reg;
   logic [31:0]     read_data_reg;
   logic            busy_reg;
   logic            done_reg;
   logic            fault_reg;
   logic            bus_valid_reg;
   logic            bus_we_reg;
   logic [31:0]     bus_addr_reg;
   logic [31:0]     bus_wdata_reg;
   logic [3:0]      bus_strb_reg;

   logic            req_illegal;
   logic [1:0]      in_addr_lo;
   logic [2:0]      sel_funct3;
   logic [1:0]      sel_addr_lo;
   logic [3:0]      lane_strb;
   logic [31:0]     lane_wdata;
   logic [31:0]     lane_rdata;
   logic            timeout;

`ifdef LSU_MISALIGN_TRAP_EN
   assign req_illegal = f3_illegal(MemWrite, Funct3) || misaligned(Funct3, Addr[1:0]);
   assign in_addr_lo  = Addr[1:0];
`else
   assign req_illegal = f3_illegal(MemWrite, Funct3);
   assign in_addr_lo  = force_align(Funct3, Addr[1:0]);
`endif

   // One lane aligner serves both paths: live inputs in IDLE, latched request afterwards.
   assign sel_funct3  = (state_reg == IDLE) ? Funct3 : funct3_reg;
   assign sel_addr_lo = (state_reg == IDLE) ? in_addr_lo : addr_lo_reg;
   assign timeout     = (cnt_reg >= TO_W'(TIMEOUT_CYCLES - 1));

   lsu_lane_align u_lane_align (
      .funct3     (sel_funct3),
      .addr_lo    (sel_addr_lo),
      .wdata      (WriteData),
      .rdata      (bus.BusRData),
      .strb       (lane_strb),
      .lane_wdata (lane_wdata),
      .rdata_ext  (lane_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         funct3_reg    <= 3'b000;
         we_reg        <= 1'b0;
         addr_lo_reg   <= 2'b00;
         cnt_reg       <= '0;
         read_data_reg <= 32'h0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         fault_reg     <= 1'b0;
         bus_valid_reg <= 1'b0;
         bus_we_reg    <= 1'b0;
         bus_addr_reg  <= 32'h0;
         bus_wdata_reg <= 32'h0;
         bus_strb_reg  <= 4'b0000;
      end else begin
         done_reg  <= 1'b0;
         fault_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (Req) begin
                  funct3_reg  <= Funct3;
                  we_reg      <= MemWrite;
                  addr_lo_reg <= in_addr_lo;
                  busy_reg    <= 1'b1;
                  if (req_illegal) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                     fault_reg <= 1'b1;
                     if (!MemWrite) read_data_reg <= 32'h0;
                  end else begin
                     state_reg     <= REQ;
                     cnt_reg       <= '0;
                     bus_valid_reg <= 1'b1;
                     bus_we_reg    <= MemWrite;
                     bus_addr_reg  <= {Addr[31:2], 2'b00};
                     bus_strb_reg  <= MemWrite ? lane_strb : 4'b0000;
                     bus_wdata_reg <= MemWrite ? lane_wdata : 32'h0;
                  end
               end
            end
            REQ: begin
               // An accepted handshake wins over a coincident timeout.
               if (bus.BusReady) begin
                  bus_valid_reg <= 1'b0;
                  cnt_reg       <= cnt_reg + TO_W'(1);
                  if (we_reg) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= RESP;
                  end
               end else if (timeout) begin
                  bus_valid_reg <= 1'b0;
                  state_reg     <= DONE;
                  done_reg      <= 1'b1;
                  fault_reg     <= 1'b1;
                  if (!we_reg) read_data_reg <= 32'h0;
               end else begin
                  cnt_reg <= cnt_reg + TO_W'(1);
               end
            end
            RESP: begin
               if (bus.BusRValid) begin
                  read_data_reg <= lane_rdata;
                  state_reg     <= DONE;
                  done_reg      <= 1'b1;
               end else if (timeout) begin
                  read_data_reg <= 32'h0;
                  state_reg     <= DONE;
                  done_reg      <= 1'b1;
                  fault_reg     <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + TO_W'(1);
               end
            end
            DONE: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign ReadData     = read_data_reg;
   assign Busy         = busy_reg;
   assign Done         = done_reg;
   assign Fault        = fault_reg;
   assign bus.BusValid = bus_valid_reg;
   assign bus.BusWe    = bus_we_reg;
   assign bus.BusAddr  = bus_addr_reg;
   assign bus.BusWData = bus_wdata_reg;
   assign bus.BusStrb  = bus_strb_reg;
endmodule
